// File: rtl/token_pkg.sv
// Shared constants and helpers for the token deserializer.
package token_pkg;

  localparam int TOKEN_W_DEFAULT = 8;

  // Width needed to hold a count of ones in a w-bit word (0..w inclusive).
  function automatic int count_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/token_fifo2.sv
// Two-entry FIFO holding completed words; the head entry is always presented on head.
module token_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [1:0]    cnt;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign head    = e0;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/token_deserializer.sv
// Serial-to-parallel token deserializer with a 2-deep output FIFO and sticky overflow.
// Optional per-word ones count on out_ones when TOKEN_DESER_POPCOUNT_EN is defined.
module token_deserializer
  import token_pkg::*;
#(
  parameter int W = TOKEN_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
`ifdef TOKEN_DESER_POPCOUNT_EN
  output logic [count_w(W)-1:0] out_ones,
`endif
  output logic                  overflow
);

  localparam int CNTW = $clog2(W);
  localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

  logic [W-1:0]    sreg;
  logic [W-1:0]    word;
  logic [CNTW-1:0] bcnt;
  logic            done;
  logic            pop;
  logic            full;
  logic            empty;

  // New bits enter at the top so the first bit ends up in bit 0 after W shifts.
  assign word = {in_bit, sreg[W-1:1]};
  assign done = in_valid && (bcnt == LAST);
  assign out_valid = !empty;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg     <= '0;
      bcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        sreg <= word;
        bcnt <= done ? '0 : bcnt + 1'b1;
      end
      if (done && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef TOKEN_DESER_POPCOUNT_EN
  localparam int CW = count_w(W);
  localparam int EW = W + CW;

  logic [CW-1:0] ones;
  logic [EW-1:0] head;

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) ones = ones + CW'(word[i]);
  end

  token_fifo2 #(.DW(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .pop   (pop),
    .din   ({ones, word}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign out_data = head[W-1:0];
  assign out_ones = head[EW-1:W];
`else
  token_fifo2 #(.DW(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .pop   (pop),
    .din   (word),
    .full  (full),
    .empty (empty),
    .head  (out_data)
  );
`endif

endmodule

// File: tb/tb_token_deserializer.sv
// Scoreboard bench for token_deserializer (W=8): directed words, gaps, overflow, reset.
module tb_token_deserializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       overflow;
`ifdef TOKEN_DESER_POPCOUNT_EN
  logic [3:0] out_ones;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] o;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  token_deserializer #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef TOKEN_DESER_POPCOUNT_EN
    .out_ones  (out_ones),
`endif
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] o);
    exp_t e;
    e.d = d;
    e.o = o;
    q.push_back(e);
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task automatic drive_bit(input logic b, input int gap);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((out_valid || q.size() != 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd0);
    check({name, "_queue"}, q.size(), 0);
  endtask

  // Monitor: a pop happens at the next edge whenever valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e.d});
`ifdef TOKEN_DESER_POPCOUNT_EN
          check("out_ones", {28'd0, out_ones}, {28'd0, e.o});
`endif
        end
      end
    end
  end

  initial begin
    logic [7:0] gaps;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    gaps      = 8'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic word, first bit in bit 0.
    push_exp(8'h8D, 4'd4);
    for (int i = 0; i < 7; i++) drive_bit(i == 0 || i == 2 || i == 3, 0);
    check("basic_pre_valid", {31'd0, out_valid}, 32'd0);
    drive_bit(1'b1, 0);
    check("basic_latency", {31'd0, out_valid}, 32'd1);
    wait_drain("basic_drain");

    // Same bits with idle gaps of 1..3 cycles.
    push_exp(8'h8D, 4'd4);
    for (int i = 0; i < 7; i++) drive_bit(i == 0 || i == 2 || i == 3, (i % 3) + 1);
    check("gap_pre_valid", {31'd0, out_valid}, 32'd0);
    drive_bit(1'b1, 0);
    check("gap_latency", {31'd0, out_valid}, 32'd1);
    wait_drain("gap_drain");

    // Overflow: third word dropped while consumer stalls.
    out_ready = 1'b0;
    push_exp(8'h01, 4'd1);
    push_exp(8'h02, 4'd1);
    send_word(8'h01);
    send_word(8'h02);
    check("ovf_before", {31'd0, overflow}, 32'd0);
    send_word(8'hFF);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_head_stable", {24'd0, out_data}, 32'h01);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_head_stable2", {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    rst = 1'b0;
    #1;
    check("ovf_rst_clear", {31'd0, overflow}, 32'd0);
    check("ovf_rst_data", {24'd0, out_data}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full FIFO, third word completes in the same cycle as a pop.
    out_ready = 1'b0;
    push_exp(8'h01, 4'd1);
    push_exp(8'h02, 4'd1);
    push_exp(8'hFF, 4'd8);
    send_word(8'h01);
    send_word(8'h02);
    for (int i = 0; i < 7; i++) drive_bit(1'b1, 0);
    out_ready = 1'b1;
    drive_bit(1'b1, 0);
    check("simul_head", {24'd0, out_data}, 32'h02);
    wait_drain("simul_drain");
    check("simul_no_ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 0);
    rst = 1'b0;
    #2;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_exp(8'h02, 4'd1);
    gaps = 8'h02;
    send_word(gaps);
    check("mid_rst_latency", {31'd0, out_valid}, 32'd1);
    wait_drain("mid_rst_drain");
    check("mid_rst_no_ovf", {31'd0, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
